// File: rtl/dm_burst.sv
// Single-port word data memory with programmable wait states and wrapping
// critical-word-first bursts. Optional per-byte write mask: DM_BYTE_MASK_EN.
module dm_burst #(
    parameter int DATA_SIZE  = 32,
    parameter int MEM_WORDS  = 4096,
    parameter int ADDR_BITS  = 14,
    parameter int BURST_LEN  = 16,
    parameter int WAIT_STATE = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   DM_enable,
    input  logic                   DM_read,
    input  logic                   DM_write,
    input  logic [ADDR_BITS-1:0]   DM_address,
    input  logic [DATA_SIZE-1:0]   DM_in,
`ifdef DM_BYTE_MASK_EN
    input  logic [DATA_SIZE/8-1:0] DM_be,
`endif
    output logic [DATA_SIZE-1:0]   DM_out,
    output logic                   DM_ack,
    output logic                   DM_last,
    output logic                   DM_busy
);

    localparam int NB     = DATA_SIZE / 8;
    localparam int WORD_W = $clog2(MEM_WORDS);
    localparam int LINE_W = $clog2(BURST_LEN);
    localparam int BEAT_W = (LINE_W > 0) ? LINE_W : 1;
    localparam logic [3:0]        WAIT_LAST = (WAIT_STATE > 0) ? 4'(WAIT_STATE - 1) : 4'd0;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [3:0]          wait_reg, wait_next;
    logic [BEAT_W-1:0]   cnt_reg, cnt_next;
    logic                ack_reg, ack_next;
    logic                last_reg, last_next;
    logic                dir_reg;          // 1 = write burst
    logic [WORD_W-1:0]   base_reg;
    logic [WORD_W-1:0]   wr_addr_reg;
    logic [DATA_SIZE-1:0] out_reg;
    logic                accept;

    logic [DATA_SIZE-1:0] mem [MEM_WORDS];

    logic [ADDR_BITS+WORD_W-3:0] addr_ext;
    logic [WORD_W-1:0]           req_word;
    logic [WORD_W-1:0]           beat_addr;
    logic [NB-1:0]               wr_be;
    logic                        unused_addr_bits;

    // Word index wraps modulo MEM_WORDS; byte-offset bits are don't-care.
    assign addr_ext         = {{WORD_W{1'b0}}, DM_address[ADDR_BITS-1:2]};
    assign req_word         = addr_ext[WORD_W-1:0];
    assign unused_addr_bits = ^{DM_address[1:0], addr_ext};

    generate
        if (LINE_W == 0) begin : g_single
            assign beat_addr = base_reg;
        end else begin : g_wrap
            logic [LINE_W-1:0] off;
            // Offset addition truncates to the line width, giving the wrap.
            assign off       = base_reg[LINE_W-1:0] + cnt_reg[LINE_W-1:0];
            assign beat_addr = {base_reg[WORD_W-1:LINE_W], off};
        end
    endgenerate

`ifdef DM_BYTE_MASK_EN
    assign wr_be = DM_be;
`else
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_full_be
            assign wr_be[gi] = 1'b1;
        end
    endgenerate
`endif

    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        cnt_next   = cnt_reg;
        ack_next   = 1'b0;
        last_next  = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (DM_enable && (DM_read ^ DM_write)) begin
                    accept     = 1'b1;
                    wait_next  = 4'd0;
                    cnt_next   = '0;
                    state_next = (WAIT_STATE == 0) ? BURST : WAIT;
                end
            end
            WAIT: begin
                if (wait_reg == WAIT_LAST) begin
                    state_next = BURST;
                end else begin
                    wait_next = wait_reg + 4'd1;
                end
            end
            BURST: begin
                // Beat issued this cycle; its ack is visible next cycle.
                ack_next  = 1'b1;
                last_next = (cnt_reg == BEAT_LAST);
                if (cnt_reg == BEAT_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            wait_reg    <= 4'd0;
            cnt_reg     <= '0;
            ack_reg     <= 1'b0;
            last_reg    <= 1'b0;
            dir_reg     <= 1'b0;
            base_reg    <= '0;
            wr_addr_reg <= '0;
        end else begin
            state_reg   <= state_next;
            wait_reg    <= wait_next;
            cnt_reg     <= cnt_next;
            ack_reg     <= ack_next;
            last_reg    <= last_next;
            wr_addr_reg <= beat_addr;
            if (accept) begin
                dir_reg  <= DM_write;
                base_reg <= req_word;
            end
        end
    end

    // Write beats land at the edge closing the acked cycle; reset aborts it.
    always_ff @(posedge clock) begin
        if (!reset && ack_reg && dir_reg) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr_reg][i*8 +: 8] <= DM_in[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_reg <= '0;
        end else if (state_reg == BURST && !dir_reg) begin
            out_reg <= mem[beat_addr];
        end
    end

    assign DM_out  = out_reg;
    assign DM_ack  = ack_reg;
    assign DM_last = last_reg;
    // Busy covers the trailing ack cycle even though the FSM is already idle.
    assign DM_busy = (state_reg != IDLE) || ack_reg;

endmodule

// File: tb/tb_dm_burst.sv
// Directed bench for dm_burst: timing, wrap order, ignored requests, abort,
// byte mask and a zero-wait single-beat instance.
module tb_dm_burst;

    localparam int NLOG = 24;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        DM_enable = 1'b1;
    logic        DM_read = 1'b1;
    logic        DM_write = 1'b0;
    logic [13:0] DM_address = '0;
    logic [31:0] DM_in = '0;
    logic [3:0]  DM_be = 4'hF;
    logic [31:0] DM_out;
    logic        DM_ack, DM_last, DM_busy;

    logic        s_enable = 1'b0;
    logic        s_read = 1'b0;
    logic        s_write = 1'b0;
    logic [9:0]  s_address = '0;
    logic [31:0] s_in = '0;
    logic [3:0]  s_be = 4'hF;
    logic [31:0] s_out;
    logic        s_ack, s_last, s_busy;

    int tests = 0;
    int fails = 0;

    logic [31:0] wdata [16];
    logic [31:0] rdata [16];
    logic        ack_log [NLOG];
    logic        last_log [NLOG];
    logic        busy_log [NLOG];
    int          nack;
    int          last_beat_ack;

    always #5 clock = ~clock;

    dm_burst #(.DATA_SIZE(32), .MEM_WORDS(4096), .ADDR_BITS(14),
               .BURST_LEN(16), .WAIT_STATE(2)) dut (
        .clock(clock), .reset(reset),
        .DM_enable(DM_enable), .DM_read(DM_read), .DM_write(DM_write),
        .DM_address(DM_address), .DM_in(DM_in),
`ifdef DM_BYTE_MASK_EN
        .DM_be(DM_be),
`endif
        .DM_out(DM_out), .DM_ack(DM_ack), .DM_last(DM_last), .DM_busy(DM_busy)
    );

    dm_burst #(.DATA_SIZE(32), .MEM_WORDS(256), .ADDR_BITS(10),
               .BURST_LEN(1), .WAIT_STATE(0)) dut_s (
        .clock(clock), .reset(reset),
        .DM_enable(s_enable), .DM_read(s_read), .DM_write(s_write),
        .DM_address(s_address), .DM_in(s_in),
`ifdef DM_BYTE_MASK_EN
        .DM_be(s_be),
`endif
        .DM_out(s_out), .DM_ack(s_ack), .DM_last(s_last), .DM_busy(s_busy)
    );

    // Drives one burst on the main instance from accept through NLOG-1 edges.
    // Called #1 after a rising edge; returns #1 after the final logged edge.
    task automatic run_burst(input logic rd, input logic [13:0] addr,
                             input int abort_beat, input int inject_edge);
        int beat;
        beat = 0;
        last_beat_ack = -1;
        DM_enable  = 1'b1;
        DM_read    = rd;
        DM_write   = ~rd;
        DM_address = addr;
        DM_in      = wdata[0];
        @(posedge clock); #1;
        DM_enable = 1'b0;
        DM_read   = 1'b0;
        DM_write  = 1'b0;
        ack_log[0]  = DM_ack;
        last_log[0] = DM_last;
        busy_log[0] = DM_busy;
        for (int e = 1; e < NLOG; e++) begin
            @(posedge clock); #1;
            ack_log[e]  = DM_ack;
            last_log[e] = DM_last;
            busy_log[e] = DM_busy;
            if (reset) reset = 1'b0;
            if (e == inject_edge) begin
                DM_enable = 1'b1;
                DM_write  = 1'b1;
            end else if (e == inject_edge + 1) begin
                DM_enable = 1'b0;
                DM_write  = 1'b0;
            end
            if (DM_ack) begin
                if (beat < 16) begin
                    if (rd) rdata[beat] = DM_out;
                    DM_in = wdata[beat];
                end
                if (DM_last) last_beat_ack = beat;
                if (beat == abort_beat) reset = 1'b1;
                beat++;
            end
        end
        nack = beat;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            @(posedge clock); #1;
            tests++;
            if (DM_ack !== 1'b0 || DM_last !== 1'b0 || DM_busy !== 1'b0 || DM_out !== 32'h0) begin
                fails++;
                $display("FAIL reset_outputs cycle %0d: ack=%b last=%b busy=%b out=%h, required all 0",
                         c, DM_ack, DM_last, DM_busy, DM_out);
            end
        end
        reset = 1'b0;
        DM_enable = 1'b0;
        DM_read = 1'b0;
        @(posedge clock); #1;
        tests++;
        if (DM_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_accept: busy=%b, required 0", DM_busy);
        end
    endtask

    task automatic test_write_burst();
        logic exp_ack, exp_last, exp_busy;
        for (int k = 0; k < 16; k++) wdata[k] = 32'h1000 + k;
        run_burst(1'b0, 14'h040, -1, -1);
        for (int e = 0; e < NLOG; e++) begin
            exp_ack  = (e >= 3 && e <= 18);
            exp_last = (e == 18);
            exp_busy = (e <= 18);
            tests++;
            if (ack_log[e] !== exp_ack || last_log[e] !== exp_last || busy_log[e] !== exp_busy) begin
                fails++;
                $display("FAIL wr_timing edge %0d: ack=%b last=%b busy=%b, required ack=%b last=%b busy=%b",
                         e, ack_log[e], last_log[e], busy_log[e], exp_ack, exp_last, exp_busy);
            end
        end
        tests++;
        if (nack !== 16) begin
            fails++;
            $display("FAIL wr_ack_count: got %0d, required 16", nack);
        end
    endtask

    task automatic test_crit_read();
        logic [31:0] exp;
        run_burst(1'b1, 14'h048, -1, -1);
        tests++;
        if (ack_log[2] !== 1'b0 || ack_log[3] !== 1'b1) begin
            fails++;
            $display("FAIL rd_first_beat: ack@2=%b ack@3=%b, required 0 and 1", ack_log[2], ack_log[3]);
        end
        for (int k = 0; k < 16; k++) begin
            exp = 32'h1000 + ((2 + k) % 16);
            tests++;
            if (rdata[k] !== exp) begin
                fails++;
                $display("FAIL rd_wrap beat %0d: got %h, required %h", k, rdata[k], exp);
            end
        end
        tests++;
        if (last_beat_ack !== 15 || rdata[15] !== 32'h1001) begin
            fails++;
            $display("FAIL rd_last: last on beat %0d data %h, required beat 15 data 00001001",
                     last_beat_ack, rdata[15]);
        end
        tests++;
        if (busy_log[18] !== 1'b1 || busy_log[19] !== 1'b0) begin
            fails++;
            $display("FAIL rd_busy_end: busy@18=%b busy@19=%b, required 1 and 0", busy_log[18], busy_log[19]);
        end
    endtask

    task automatic test_ignored();
        for (int k = 0; k < 16; k++) wdata[k] = 32'hDEADBEEF;
        run_burst(1'b1, 14'h040, -1, 5);
        tests++;
        if (nack !== 16) begin
            fails++;
            $display("FAIL ign_ack_count: got %0d, required 16", nack);
        end
        DM_enable = 1'b1;
        DM_read = 1'b1;
        DM_write = 1'b1;
        DM_address = 14'h040;
        @(posedge clock); #1;
        DM_enable = 1'b0;
        DM_read = 1'b0;
        DM_write = 1'b0;
        tests++;
        if (DM_busy !== 1'b0) begin
            fails++;
            $display("FAIL ign_illegal_busy: busy=%b, required 0", DM_busy);
        end
        @(posedge clock); #1;
        tests++;
        if (DM_busy !== 1'b0 || DM_ack !== 1'b0) begin
            fails++;
            $display("FAIL ign_illegal_idle: busy=%b ack=%b, required 0 0", DM_busy, DM_ack);
        end
        run_burst(1'b1, 14'h040, -1, -1);
        for (int k = 0; k < 16; k++) begin
            tests++;
            if (rdata[k] !== 32'h1000 + k) begin
                fails++;
                $display("FAIL ign_mem word %0d: got %h, required %h", 16 + k, rdata[k], 32'h1000 + k);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] exp;
        for (int k = 0; k < 16; k++) wdata[k] = 32'hA000 + k;
        run_burst(1'b0, 14'h080, -1, -1);
        for (int k = 0; k < 16; k++) wdata[k] = 32'hB000 + k;
        run_burst(1'b0, 14'h080, 5, -1);
        tests++;
        if (nack !== 6 || ack_log[8] !== 1'b1 || ack_log[9] !== 1'b0 || busy_log[9] !== 1'b0) begin
            fails++;
            $display("FAIL abort_outputs: acks=%0d ack@8=%b ack@9=%b busy@9=%b, required 6 1 0 0",
                     nack, ack_log[8], ack_log[9], busy_log[9]);
        end
        run_burst(1'b1, 14'h080, -1, -1);
        for (int k = 0; k < 16; k++) begin
            exp = (k < 5) ? 32'hB000 + k : 32'hA000 + k;
            tests++;
            if (rdata[k] !== exp) begin
                fails++;
                $display("FAIL abort_mem word %0d: got %h, required %h", 32 + k, rdata[k], exp);
            end
        end
    endtask

    task automatic test_byte_mask();
        logic [31:0] exp;
`ifdef DM_BYTE_MASK_EN
        exp = 32'h1234FFFF;
`else
        exp = 32'hFFFFFFFF;
`endif
        for (int k = 0; k < 16; k++) wdata[k] = 32'h12345678;
        DM_be = 4'hF;
        run_burst(1'b0, 14'h0C0, -1, -1);
        for (int k = 0; k < 16; k++) wdata[k] = 32'hFFFFFFFF;
        DM_be = 4'b0011;
        run_burst(1'b0, 14'h0C0, -1, -1);
        DM_be = 4'hF;
        run_burst(1'b1, 14'h0C0, -1, -1);
        for (int k = 0; k < 16; k += 5) begin
            tests++;
            if (rdata[k] !== exp) begin
                fails++;
                $display("FAIL byte_mask beat %0d: got %h, required %h", k, rdata[k], exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        s_enable = 1'b1;
        s_write = 1'b1;
        s_address = 10'h010;
        s_in = 32'h5A5A0001;
        @(posedge clock); #1;
        s_enable = 1'b0;
        s_write = 1'b0;
        tests++;
        if (s_busy !== 1'b1 || s_ack !== 1'b0) begin
            fails++;
            $display("FAIL b2b_accept: busy=%b ack=%b, required 1 0", s_busy, s_ack);
        end
        @(posedge clock); #1;
        tests++;
        if (s_ack !== 1'b1 || s_last !== 1'b1 || s_busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_wr_beat: ack=%b last=%b busy=%b, required 1 1 1", s_ack, s_last, s_busy);
        end
        s_enable = 1'b1;
        s_read = 1'b1;
        @(posedge clock); #1;
        s_enable = 1'b0;
        s_read = 1'b0;
        tests++;
        if (s_busy !== 1'b1 || s_ack !== 1'b0) begin
            fails++;
            $display("FAIL b2b_next_accept: busy=%b ack=%b, required 1 0", s_busy, s_ack);
        end
        @(posedge clock); #1;
        tests++;
        if (s_ack !== 1'b1 || s_last !== 1'b1 || s_out !== 32'h5A5A0001) begin
            fails++;
            $display("FAIL b2b_rd_beat: ack=%b last=%b out=%h, required 1 1 5a5a0001", s_ack, s_last, s_out);
        end
        @(posedge clock); #1;
        tests++;
        if (s_ack !== 1'b0 || s_busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end: ack=%b busy=%b, required 0 0", s_ack, s_busy);
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_crit_read();
        test_ignored();
        test_reset_mid_burst();
        test_byte_mask();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
